// File: rtl/add32_seq.sv
// Multi-word adder sequencer: streams NWORDS 32-bit word pairs, least-significant first,
// through a shared external add32 and carries between words in a register.
module add32_seq #(
  parameter int NWORDS = 4
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        op_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_last,
  output logic        out_cout,
  output logic        out_ovf,
  output logic        busy,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  output logic        adder_cin,
  output logic        adder_add,
  input  logic [31:0] adder_sum,
  input  logic        adder_cout
);

  localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCW-1:0] LAST_IDX = WCW'(NWORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t         state_r, state_s;
  logic [WCW-1:0] wcnt_r, wcnt_s;
  logic           creg_r, creg_s;
  logic           out_valid_r, out_valid_s;
  logic [31:0]    out_sum_r, out_sum_s;
  logic           out_last_r, out_last_s;
  logic           out_cout_r, out_cout_s;
  logic           out_ovf_r, out_ovf_s;
  logic           in_ready_s, accept_s, last_s;

  // Handshake, adder drive and next-state selection
  always_comb begin
    in_ready_s  = !p_reset && !clear && (!out_valid_r || out_ready);
    accept_s    = in_valid && in_ready_s;
    last_s      = (wcnt_r == LAST_IDX);
    state_s     = state_r;
    wcnt_s      = wcnt_r;
    creg_s      = creg_r;
    out_valid_s = out_valid_r;
    out_sum_s   = out_sum_r;
    out_last_s  = out_last_r;
    out_cout_s  = out_cout_r;
    out_ovf_s   = out_ovf_r;
    if (clear) begin
      state_s     = IDLE;
      wcnt_s      = {WCW{1'b0}};
      creg_s      = 1'b0;
      out_valid_s = 1'b0;
    end else if (accept_s) begin
      out_valid_s = 1'b1;
      out_sum_s   = adder_sum;
      out_cout_s  = adder_cout;
      out_last_s  = last_s;
      out_ovf_s   = last_s && signed_ovf(in_a[31], in_b[31], adder_sum[31]);
      if (last_s) begin
        state_s = IDLE;
        wcnt_s  = {WCW{1'b0}};
        creg_s  = 1'b0;
      end else begin
        state_s = RUN;
        wcnt_s  = wcnt_r + WCW'(1);
        creg_s  = adder_cout;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_r     <= IDLE;
      wcnt_r      <= {WCW{1'b0}};
      creg_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= 32'h0000_0000;
      out_last_r  <= 1'b0;
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      wcnt_r      <= wcnt_s;
      creg_r      <= creg_s;
      out_valid_r <= out_valid_s;
      out_sum_r   <= out_sum_s;
      out_last_r  <= out_last_s;
      out_cout_r  <= out_cout_s;
      out_ovf_r   <= out_ovf_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign adder_add = accept_s;
  assign adder_a   = in_a;
  assign adder_b   = in_b;
  // Word 0 takes the operation carry; later words take the held inter-word carry
  assign adder_cin = (state_r == IDLE) ? op_cin : creg_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_last  = out_last_r;
  assign out_cout  = out_cout_r;
  assign out_ovf   = out_ovf_r;
  assign busy      = (state_r == RUN);

endmodule

// File: tb/tb_add32_seq.sv
// Bench for add32_seq: full-width arithmetic model with per-cycle compare,
// plus directed operations with hand-computed literal expectations.
module tb_add32_seq;
  localparam int NW = 4;

  logic        m_clock, p_reset, clear, in_valid, in_ready, op_cin;
  logic [31:0] in_a, in_b, out_sum, adder_a, adder_b, adder_sum;
  logic        out_valid, out_ready, out_last, out_cout, out_ovf, busy;
  logic        adder_cin, adder_add, adder_cout;

  add32_seq #(.NWORDS(NW)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin), .adder_add(adder_add),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  // Behavioural add32
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        last;
    logic        ovf;
  } res_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          kidx = 0;
  logic        mon_en = 1'b0;
  logic [31:0] op_a [NW];
  logic [31:0] op_b [NW];
  res_t        exp_q[$];
  res_t        seen[$];
  int          seen_cyc[$];
  logic        seen_cin[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Full-width sum of the low n word pairs plus the operation carry
  function automatic logic [32*NW:0] partial(input int n);
    logic [32*NW:0] s;
    s = {{(32*NW){1'b0}}, op_cin};
    for (int i = 0; i < n; i++) begin
      s = s + ({{(32*NW-31){1'b0}}, op_a[i]} << (32*i))
            + ({{(32*NW-31){1'b0}}, op_b[i]} << (32*i));
    end
    return s;
  endfunction

  always @(posedge m_clock) cyc++;

  // Per-cycle compare against the model, then advance the model across the coming edge
  always @(negedge m_clock) begin : mon
    logic           exp_rdy, exp_acc, a_s, b_s, s_s;
    logic [32*NW:0] p, q;
    res_t           r;
    if (mon_en) begin
      chk1("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk32("out_sum", out_sum, exp_q[0].sum);
        chk1("out_cout", out_cout, exp_q[0].cout);
        chk1("out_last", out_last, exp_q[0].last);
        chk1("out_ovf", out_ovf, exp_q[0].ovf);
      end
      exp_rdy = !p_reset && !clear && (exp_q.size() == 0 || out_ready);
      exp_acc = exp_rdy && in_valid;
      chk1("in_ready", in_ready, exp_rdy);
      chk1("adder_add", adder_add, exp_acc);
      chk1("busy", busy, kidx != 0);
      if (p_reset || clear) begin
        exp_q.delete();
        kidx = 0;
      end else begin
        if (exp_q.size() > 0 && out_ready) begin
          r.sum = out_sum; r.cout = out_cout; r.last = out_last; r.ovf = out_ovf;
          seen.push_back(r);
          seen_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
        if (exp_acc) begin
          q = partial(kidx);
          p = partial(kidx + 1);
          chk32("adder_a", adder_a, op_a[kidx]);
          chk32("adder_b", adder_b, op_b[kidx]);
          chk1("adder_cin", adder_cin, q[32*kidx]);
          seen_cin.push_back(adder_cin);
          a_s = op_a[NW-1][31];
          b_s = op_b[NW-1][31];
          s_s = p[32*NW-1];
          r.sum  = p[32*kidx +: 32];
          r.cout = p[32*(kidx+1)];
          r.last = (kidx == NW-1);
          r.ovf  = (kidx == NW-1) && (a_s == b_s) && (s_s != a_s);
          exp_q.push_back(r);
          kidx = (kidx == NW-1) ? 0 : kidx + 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge m_clock);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3, input logic cin);
    op_a[0] = a0; op_a[1] = a1; op_a[2] = a2; op_a[3] = a3;
    op_b[0] = b0; op_b[1] = b1; op_b[2] = b2; op_b[3] = b3;
    op_cin  = cin;
  endtask

  task automatic send_word(input int i);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = op_a[i];
    in_b = op_b[i];
    while (!acc && n < 50) begin
      @(negedge m_clock);
      acc = in_ready;
      @(posedge m_clock);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout: word %0d got no accept, required accept within 50 cycles", i);
    end
  endtask

  task automatic run_op();
    seen.delete();
    seen_cyc.delete();
    seen_cin.delete();
    for (int i = 0; i < NW; i++) send_word(i);
    in_valid = 1'b0;
    idle(2);
  endtask

  initial begin
    p_reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 32'd0; in_b = 32'd0; op_cin = 1'b0;
    idle(2);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_sum", out_sum, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    p_reset = 1'b0;
    out_ready = 1'b1;
    mon_en = 1'b1;

    // Carry ripples through every word
    load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'h1, 32'h0, 32'h0, 32'h0, 1'b0);
    run_op();
    chk32("t1_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk32("t1_sum", seen[i].sum, 32'h0);
        chk1("t1_cout", seen[i].cout, 1'b1);
        chk1("t1_last", seen[i].last, i == 3);
        chk1("t1_ovf", seen[i].ovf, 1'b0);
      end
      chk32("t1_consecutive", 32'(seen_cyc[3] - seen_cyc[0]), 32'd3);
    end

    // Operation carry-in used only on word 0
    load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_op();
    chk32("t2_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4 && seen_cin.size() == 4) begin
      chk32("t2_sum0", seen[0].sum, 32'h1);
      for (int i = 1; i < 4; i++) chk32("t2_sumhi", seen[i].sum, 32'h0);
      for (int i = 0; i < 4; i++) chk1("t2_cout", seen[i].cout, 1'b0);
      chk1("t2_cin0", seen_cin[0], 1'b1);
      for (int i = 1; i < 4; i++) chk1("t2_cinhi", seen_cin[i], 1'b0);
    end

    // Signed overflow, positive operands
    load(32'h0, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0);
    run_op();
    if (seen.size() == 4) begin
      chk32("t3_sum", seen[3].sum, 32'h80000000);
      chk1("t3_ovf", seen[3].ovf, 1'b1);
      chk1("t3_cout", seen[3].cout, 1'b0);
    end

    // Signed overflow, negative operands
    load(32'h0, 32'h0, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h80000000, 1'b0);
    run_op();
    if (seen.size() == 4) begin
      chk32("t4_sum", seen[3].sum, 32'h0);
      chk1("t4_ovf", seen[3].ovf, 1'b1);
      chk1("t4_cout", seen[3].cout, 1'b1);
    end

    // Backpressure after the first result
    load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'h2, 32'h0, 32'h0, 32'h0, 1'b0);
    seen.delete();
    send_word(0);
    out_ready = 1'b0;
    in_a = op_a[1];
    in_b = op_b[1];
    repeat (3) begin
      @(negedge m_clock);
      chk1("t5_in_ready", in_ready, 1'b0);
      chk1("t5_adder_add", adder_add, 1'b0);
      chk32("t5_sum_hold", out_sum, 32'h1);
      chk1("t5_busy", busy, 1'b1);
      @(posedge m_clock);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 1; i < NW; i++) send_word(i);
    in_valid = 1'b0;
    idle(2);
    chk32("t5_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk32("t5_sum0", seen[0].sum, 32'h1);
      for (int i = 1; i < 4; i++) chk32("t5_sumhi", seen[i].sum, 32'h0);
      for (int i = 0; i < 4; i++) chk1("t5_cout", seen[i].cout, 1'b1);
      chk1("t5_last", seen[3].last, 1'b1);
    end

    // Clear mid-operand with carry pending
    load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'h1, 32'h0, 32'h0, 32'h0, 1'b0);
    send_word(0);
    send_word(1);
    in_valid = 1'b0;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk1("t6_valid_after_clear", out_valid, 1'b0);
    chk1("t6_busy_after_clear", busy, 1'b0);
    load(32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0);
    run_op();
    chk32("t6_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk32("t6_sum0", seen[0].sum, 32'h2);
      chk1("t6_last0", seen[0].last, 1'b0);
      chk1("t6_last3", seen[3].last, 1'b1);
    end

    // Reset mid-operand
    load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'h1, 32'h5, 32'h0, 32'h0, 1'b0);
    send_word(0);
    send_word(1);
    in_a = op_a[2];
    in_b = op_b[2];
    p_reset = 1'b1;
    @(negedge m_clock);
    chk1("t7_in_ready_rst", in_ready, 1'b0);
    chk1("t7_adder_add_rst", adder_add, 1'b0);
    @(posedge m_clock);
    #1;
    p_reset = 1'b0;
    in_valid = 1'b0;
    chk1("t7_out_valid", out_valid, 1'b0);
    chk32("t7_out_sum", out_sum, 32'h0);
    chk1("t7_out_cout", out_cout, 1'b0);
    chk1("t7_out_last", out_last, 1'b0);
    chk1("t7_busy", busy, 1'b0);
    load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_op();
    chk32("t7_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4 && seen_cin.size() == 4) begin
      chk32("t7_sum0", seen[0].sum, 32'h1);
      chk1("t7_cin0", seen_cin[0], 1'b1);
      chk1("t7_last3", seen[3].last, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
